// File: rtl/spo2_ratio_calc.sv
`default_nettype none
// spo2_ratio_calc (rev 1.0): windowed min/max tracking of red and IR ADC samples, AC/DC
// extraction and a serial restoring divider producing R = (AC_red*DC_ir)/(AC_ir*DC_red).
module spo2_ratio_calc #(
  parameter int WINDOW  = 100,
  parameter int FRAC    = 8,
  parameter int RATIO_W = 12
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               Enable,
  input  logic               LED_RED,
  input  logic               LED_IR,
  input  logic [7:0]         RED_ADC_Value,
  input  logic [7:0]         IR_ADC_Value,
  output logic [RATIO_W-1:0] Ratio,
  output logic               Ratio_Valid,
  output logic               Div_Err,
  output logic               Busy
);

  localparam int QW = 16 + FRAC;
  localparam int SW = $clog2(QW);
  localparam logic [7:0]    C_WINDOW    = 8'(WINDOW);
  localparam logic [SW-1:0] C_LAST_STEP = SW'(QW - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_MULT    = 3'd2,
    S_DIVIDE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q;
  logic               led_red_q, led_ir_q;
  logic [7:0]         min_r_q, max_r_q, min_i_q, max_i_q;
  logic [7:0]         cnt_r_q, cnt_i_q;
  logic [15:0]        den_q;
  logic [15:0]        rem_q;
  logic [QW-1:0]      dvd_q;
  logic [QW-1:0]      q_q;
  logic [SW-1:0]      step_q;

  logic               cap_r_d, cap_i_d, clr_trk_d, den_zero_d, fits_d;
  logic [7:0]         ac_r_d, dc_r_d, ac_i_d, dc_i_d;
  logic [15:0]        num_d, den_d;
  logic [16:0]        rem_sh_d;
  logic [QW-1:0]      q_next_d;
  logic [RATIO_W-1:0] ratio_d;

  always_comb begin
    cap_r_d    = led_red_q & ~LED_RED;
    cap_i_d    = led_ir_q & ~LED_IR;
    clr_trk_d  = (state_q == S_IDLE) || (state_q == S_DONE) ||
                 ((state_q == S_COLLECT) && !Enable);
    ac_r_d     = max_r_q - min_r_q;
    ac_i_d     = max_i_q - min_i_q;
    dc_r_d     = 8'(({1'b0, max_r_q} + {1'b0, min_r_q}) >> 1);
    dc_i_d     = 8'(({1'b0, max_i_q} + {1'b0, min_i_q}) >> 1);
    num_d      = {8'd0, ac_r_d} * {8'd0, dc_i_d};
    den_d      = {8'd0, ac_i_d} * {8'd0, dc_r_d};
    den_zero_d = (den_q == 16'd0);
    rem_sh_d   = {rem_q, dvd_q[QW-1]};
    fits_d     = (rem_sh_d >= {1'b0, den_q});
    // A zero divisor keeps the all-ones quotient preloaded in MULT
    q_next_d   = den_zero_d ? q_q : {q_q[QW-2:0], fits_d};
    ratio_d    = (|q_next_d[QW-1:RATIO_W]) ? '1 : q_next_d[RATIO_W-1:0];
  end

  assign Busy = (state_q == S_MULT) || (state_q == S_DIVIDE) || (state_q == S_DONE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      led_red_q   <= 1'b0;
      led_ir_q    <= 1'b0;
      min_r_q     <= 8'hFF;
      max_r_q     <= 8'h00;
      min_i_q     <= 8'hFF;
      max_i_q     <= 8'h00;
      cnt_r_q     <= 8'h00;
      cnt_i_q     <= 8'h00;
      den_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      q_q         <= '0;
      step_q      <= '0;
      Ratio       <= '0;
      Ratio_Valid <= 1'b0;
      Div_Err     <= 1'b0;
    end else begin
      led_red_q   <= LED_RED;
      led_ir_q    <= LED_IR;
      Ratio_Valid <= 1'b0;

      if (clr_trk_d) begin
        min_r_q <= 8'hFF;
        max_r_q <= 8'h00;
        min_i_q <= 8'hFF;
        max_i_q <= 8'h00;
        cnt_r_q <= 8'h00;
        cnt_i_q <= 8'h00;
      end else if (state_q == S_COLLECT) begin
        if (cap_r_d && (cnt_r_q != C_WINDOW)) begin
          cnt_r_q <= cnt_r_q + 8'd1;
          if (RED_ADC_Value < min_r_q) min_r_q <= RED_ADC_Value;
          if (RED_ADC_Value > max_r_q) max_r_q <= RED_ADC_Value;
        end
        if (cap_i_d && (cnt_i_q != C_WINDOW)) begin
          cnt_i_q <= cnt_i_q + 8'd1;
          if (IR_ADC_Value < min_i_q) min_i_q <= IR_ADC_Value;
          if (IR_ADC_Value > max_i_q) max_i_q <= IR_ADC_Value;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (Enable) state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          if (!Enable) state_q <= S_IDLE;
          else if ((cnt_r_q == C_WINDOW) && (cnt_i_q == C_WINDOW)) state_q <= S_MULT;
        end
        S_MULT: begin
          den_q   <= den_d;
          dvd_q   <= {num_d, {FRAC{1'b0}}};
          rem_q   <= '0;
          q_q     <= (den_d == 16'd0) ? '1 : '0;
          step_q  <= '0;
          state_q <= S_DIVIDE;
        end
        S_DIVIDE: begin
          q_q    <= q_next_d;
          step_q <= step_q + SW'(1);
          if (!den_zero_d) begin
            dvd_q <= dvd_q << 1;
            rem_q <= fits_d ? 16'(rem_sh_d - {1'b0, den_q}) : rem_sh_d[15:0];
          end
          if (step_q == C_LAST_STEP) begin
            Ratio       <= ratio_d;
            Div_Err     <= den_zero_d;
            Ratio_Valid <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= Enable ? S_COLLECT : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/spo2_ratio_calc.md
Name: spo2_ratio_calc

Overview:
- Reads the per-phase ADC results that the LED/PGA controller publishes on RED_ADC_Value and IR_ADC_Value.
- Over a fixed window of samples per channel, tracks the peak and trough of each channel and derives AC = max − min and DC = (max + min) >> 1.
- Computes the ratio-of-ratios R = (AC_red·DC_ir)/(AC_ir·DC_red) in unsigned fixed point with a serial divider.
- Sits between the controller and the SpO2 lookup/display logic.

Parameters:
WINDOW, 100, samples per channel per ratio computation (2..255)
FRAC, 8, fractional bits of R
RATIO_W, 12, output width of R; integer bits = RATIO_W − FRAC

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
Enable  in  1  high = run; tie to controller's setting-complete flag
LED_RED  in  1  red LED phase from controller
LED_IR  in  1  IR LED phase from controller
RED_ADC_Value  in  8  latest red ADC sample, held by controller
IR_ADC_Value  in  8  latest IR ADC sample, held by controller
Ratio  out  RATIO_W  R in unsigned Q(RATIO_W−FRAC).FRAC
Ratio_Valid  out  1  one-cycle pulse when Ratio updates
Div_Err  out  1  AC_ir·DC_red was zero for the last result
Busy  out  1  high in MULT/DIVIDE/DONE

Behaviour:
- Reset: Clock and reset are fixed as one clock, CLK, with asynchronous active-low reset rst_n. While rst_n is low, all state is cleared:
  - Ratio = 0, Ratio_Valid = 0, Div_Err = 0, Busy = 0.
  - FSM = IDLE; min trackers = 255, max trackers = 0, counters = 0.
  - Edge-detect registers = 0.
- Sample capture:
  - Registered copies of LED_RED and LED_IR provide edge detection.
  - A red sample is captured on the CLK edge where LED_RED is seen 0 with its previous value 1, i.e. at the end of the red phase. The value captured is RED_ADC_Value.
  - IR samples are captured the same way, using LED_IR and IR_ADC_Value.
  - A capture updates that channel's min, max and count, all registered.
  - Captures are honoured only in COLLECT. In any other state they are dropped.
  - A channel whose count has reached WINDOW ignores further captures until the window closes.
  - Simultaneous red and IR falling edges: both are captured in the same cycle.
- FSM:
  - IDLE: trackers held at reset values. Go to COLLECT when Enable = 1.
  - COLLECT: capture samples. When both counts equal WINDOW, go to MULT.
  - MULT (1 cycle):
    - AC_r, DC_r, AC_i, DC_i computed as 8-bit values.
    - NUM = AC_r·DC_i and DEN = AC_i·DC_r, each 16 bits, registered.
  - DIVIDE (16 + FRAC cycles):
    - Restoring divider, one quotient bit per cycle, computing Q = (NUM << FRAC) / DEN.
    - Q is 16 + FRAC bits; remainder is discarded (truncate).
    - If DEN = 0, skip the arithmetic but still spend the full cycle count. Q is forced to all-ones and Div_Err is set.
  - DONE (1 cycle):
    - Ratio = Q[RATIO_W−1:0], or all-ones if Q ≥ 2^RATIO_W (saturate).
    - Div_Err is updated. Ratio_Valid = 1 for this cycle only.
    - Trackers and counters are reset. Return to COLLECT, or to IDLE if Enable = 0.
- Enable low:
  - In COLLECT: go to IDLE next cycle and discard the partial window.
  - In MULT/DIVIDE: the computation completes and results are published, then the FSM goes to IDLE.
- Outputs: Ratio and Div_Err hold their last result until the next DONE or reset.
- Latency: from the capture edge that completes the window to the cycle in which Ratio_Valid is high = 3 + 16 + FRAC cycles (27 at default). This is exact and fixed, including in the DEN = 0 case.
- Reset mid-operation: rst_n low at any point aborts immediately. No Ratio_Valid is produced and all outputs return to reset values.

Test Plan:
1. Ratio of 2.0:
   - Stimulus: WINDOW = 4; red samples alternate 100/140 (AC 40, DC 120); IR samples alternate 110/130 (AC 20, DC 120); LEDs alternate at 10-cycle phases.
   - Required: NUM = 4800, DEN = 2400; Ratio = 0x200, Div_Err = 0; Ratio_Valid pulses exactly 27 cycles after the 4th IR capture.
2. Zero denominator: IR samples constant 128, red as in scenario 1 → Ratio = 0xFFF, Div_Err = 1, latency still 27.
3. Saturation: red samples alternate 0/255 (AC 255, DC 127); IR samples alternate 127/128 (AC 1, DC 127) → Q = 255.0 ≥ 16; Ratio = 0xFFF, Div_Err = 0.
4. Excess samples:
   - Stimulus: 6 red falling edges before any IR edge; red values 100, 140, 100, 140, then 0, 255.
   - Required: red captures 5 and 6 are ignored, and the result equals scenario 1 (0x200).
5. Enable dropped:
   - Enable dropped mid-COLLECT after 2 samples, then re-raised → the first window is discarded; a full fresh window is required and yields 0x200.
   - Enable dropped mid-DIVIDE → Ratio_Valid still pulses, then the FSM sits in IDLE.
6. Reset mid-operation: assert rst_n low at DIVIDE cycle 10 → no Ratio_Valid; Ratio = 0, Busy = 0 immediately; after release the block sits in IDLE until Enable = 1.
